// File: rtl/seg_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_driver_pkg
//
// Purpose:
//    Shared constants, types and small helpers for the seven-segment scan
//    driver and its hex decoder.
//
// Contents:
//    SEG_BLANK    - all segments off (active-low bus).
//    AN_OFF       - all digit anodes off (active-low).
//    dig_t        - 2-bit digit slot index.
//    DIG_*        - which source each digit slot shows.
//    an_select()  - active-low one-hot anode pattern for a digit index.
//    lit_cycles() - length of the lit window for a given dimming level.
//
// Build option:
//    SEG_SCAN_DIM_EN - when defined, the top level adds PWM dimming. The
//    package itself is identical in both builds.
// ---------------------------------------------------------------------------
package seg_scan_driver_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   typedef logic [1:0] dig_t;

   localparam dig_t DIG_REG1 = 2'd0;
   localparam dig_t DIG_REG2 = 2'd1;
   localparam dig_t DIG_SWLO = 2'd2;
   localparam dig_t DIG_SWHI = 2'd3;

   // Anodes are active-low, so the selected digit is the single zero.
   function automatic logic [3:0] an_select(input dig_t dig);
      return ~(4'b0001 << dig);
   endfunction

   // Number of lit cycles after blanking for a dimming level.
   // Level 3 gives the whole window, level 0 a quarter of it.
   function automatic int lit_cycles(input logic [1:0] level, input int width);
      return ((int'(level) + 1) * width) / 4;
   endfunction

endpackage

// File: rtl/seg_scan_driver_hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
//
// Purpose:
//    Combinational decoder from a 4-bit value to an active-low
//    seven-segment pattern. Bit order of seg is {g,f,e,d,c,b,a}. Letters
//    b and d are lower case so that they look different from 8 and 0.
//
// Ports:
//    hex  in  4  value to show (0..F)
//    seg  out 7  active-low segment pattern {g..a}
// ---------------------------------------------------------------------------
module hex7seg
   import seg_scan_driver_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   // Full lookup. The default keeps the block latch-free even though all
   // sixteen codes are listed.
   always_comb begin
      seg = SEG_BLANK;
      case (hex)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         4'hF:    seg = 7'b0001110;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Purpose:
//    Display back-end for the processor. Time-multiplexes the register-1
//    and register-2 segment patterns and the two hex nibbles of the switch
//    operand onto one 4-digit common-anode seven-segment display.
//
//    A refresh counter divides time into slots of REFRESH_DIV cycles. Each
//    slot starts with BLANK_CYCLES cycles of all anodes off so that the
//    segment bus can change without ghosting. All inputs are snapshotted at
//    the start of every slot, so input changes mid-slot never disturb the
//    lit digit. Slot order: reg1, reg2, sw[3:0], sw[7:4]. The decimal point
//    is lit alongside the sw[3:0] digit to mark the operand field.
//
// Parameters:
//    REFRESH_DIV   clock cycles per digit slot (>= 2)
//    BLANK_CYCLES  blanked cycles at the start of every slot (< REFRESH_DIV)
//
// Ports:
//    clk       in   1  system clock
//    rst       in   1  synchronous active-low reset
//    reg1_seg  in   7  register-1 pattern, active-low {g..a}
//    reg2_seg  in   7  register-2 pattern, active-low {g..a}
//    sw_in     in   8  switch operand
//    bright    in   2  dimming level, 3 = full on (SEG_SCAN_DIM_EN only)
//    seg_out   out  7  shared segment bus, active-low {g..a}
//    an_out    out  4  digit anodes, active-low
//    dp_out    out  1  decimal point, active-low
//
// Build option:
//    SEG_SCAN_DIM_EN - adds the bright port and PWM dimming: the anode is
//    lit only for the first ((bright+1)*W)/4 cycles after blanking, where
//    W = REFRESH_DIV - BLANK_CYCLES. Without it the anode is lit for all W.
// ---------------------------------------------------------------------------
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] reg1_seg,
   input  logic [6:0] reg2_seg,
   input  logic [7:0] sw_in,
`ifdef SEG_SCAN_DIM_EN
   input  logic [1:0] bright,
`endif
   output logic [6:0] seg_out,
   output logic [3:0] an_out,
   output logic       dp_out
);

   localparam int              CNT_W   = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);

   // Current state
   logic [CNT_W-1:0] cnt;
   dig_t             dig;
   logic             running;
   logic [6:0]       snap_reg1;
   logic [6:0]       snap_reg2;
   logic [7:0]       snap_sw;

   // Next state
   logic [CNT_W-1:0] cnt_next;
   dig_t             dig_next;
   logic             slot_start;
   logic [6:0]       reg1_next;
   logic [6:0]       reg2_next;
   logic [7:0]       sw_next;

   // Output values that will be registered this edge
   logic [6:0]       seg_next;
   logic [3:0]       an_next;
   logic             dp_next;
   logic             lit;

   logic [6:0]       hex_lo;
   logic [6:0]       hex_hi;

`ifdef SEG_SCAN_DIM_EN
   logic [1:0]       snap_bright;
   logic [1:0]       bright_next;
   int               lit_end;
`endif

   // The first edge after reset release opens slot 0 with cnt held at 0,
   // so slot 0 gets its full BLANK_CYCLES of blanking just like every other
   // slot. After that, cnt counts up and each wrap opens the next slot.
   always_comb begin
      cnt_next   = cnt + 1'b1;
      dig_next   = dig;
      slot_start = 1'b0;
      if (!running) begin
         cnt_next   = '0;
         slot_start = 1'b1;
      end else if (cnt == CNT_MAX) begin
         cnt_next   = '0;
         dig_next   = dig + 2'd1;
         slot_start = 1'b1;
      end
   end

   // Inputs are sampled only when a slot opens; between slot starts the
   // snapshot is held, which keeps the lit digit stable.
   always_comb begin
      reg1_next = snap_reg1;
      reg2_next = snap_reg2;
      sw_next   = snap_sw;
      if (slot_start) begin
         reg1_next = reg1_seg;
         reg2_next = reg2_seg;
         sw_next   = sw_in;
      end
   end

`ifdef SEG_SCAN_DIM_EN
   // The dimming level belongs to the slot snapshot as well.
   always_comb begin
      bright_next = snap_bright;
      if (slot_start) begin
         bright_next = bright;
      end
   end
`endif

   // Operand nibbles are decoded from the next-state snapshot so that a new
   // slot shows its own digit on its very first edge.
   hex7seg u_hex_lo (
      .hex (sw_next[3:0]),
      .seg (hex_lo)
   );

   hex7seg u_hex_hi (
      .hex (sw_next[7:4]),
      .seg (hex_hi)
   );

   // Outputs are derived from next-state cnt/dig so the registered outputs
   // line up with the slot the counter is in, without a cycle of lag.
   always_comb begin
      seg_next = SEG_BLANK;
      case (dig_next)
         DIG_REG1: seg_next = reg1_next;
         DIG_REG2: seg_next = reg2_next;
         DIG_SWLO: seg_next = hex_lo;
         DIG_SWHI: seg_next = hex_hi;
         default:  seg_next = SEG_BLANK;
      endcase

`ifdef SEG_SCAN_DIM_EN
      lit_end = BLANK_CYCLES + lit_cycles(bright_next, REFRESH_DIV - BLANK_CYCLES);
      lit     = (cnt_next >= BLANK_C) && (int'(cnt_next) < lit_end);
`else
      lit     = (cnt_next >= BLANK_C);
`endif

      an_next = lit ? an_select(dig_next) : AN_OFF;
      dp_next = !(lit && (dig_next == DIG_SWLO));
   end

   // Single state register. Reset takes priority over a slot wrap on the
   // same edge and aborts whatever slot was in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt         <= '0;
         dig         <= DIG_REG1;
         running     <= 1'b0;
         snap_reg1   <= '0;
         snap_reg2   <= '0;
         snap_sw     <= '0;
`ifdef SEG_SCAN_DIM_EN
         snap_bright <= '0;
`endif
         seg_out     <= SEG_BLANK;
         an_out      <= AN_OFF;
         dp_out      <= 1'b1;
      end else begin
         cnt         <= cnt_next;
         dig         <= dig_next;
         running     <= 1'b1;
         snap_reg1   <= reg1_next;
         snap_reg2   <= reg2_next;
         snap_sw     <= sw_next;
`ifdef SEG_SCAN_DIM_EN
         snap_bright <= bright_next;
`endif
         seg_out     <= seg_next;
         an_out      <= an_next;
         dp_out      <= dp_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Purpose:
//    Self-checking bench for seg_scan_driver with REFRESH_DIV=8 and
//    BLANK_CYCLES=2. A reference model tracks the number of edges since
//    reset release and derives slot position, digit and snapshot from that
//    count. Every edge is compared against it; explicit constant checks
//    cover reset, scan order, snapshot hold, mid-slot reset, wrap and the
//    operand hex table. Builds with or without SEG_SCAN_DIM_EN.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

   localparam int RD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = 4 * RD;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] reg1_seg;
   logic [6:0] reg2_seg;
   logic [7:0] sw_in;
`ifdef SEG_SCAN_DIM_EN
   logic [1:0] bright;
`endif
   logic [6:0] seg_out;
   logic [3:0] an_out;
   logic       dp_out;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int         t = -1;
   logic [6:0] m_r1 = '0;
   logic [6:0] m_r2 = '0;
   logic [7:0] m_sw = '0;
   logic [1:0] m_br = 2'd3;
   logic [6:0] exp_seg;
   logic [3:0] exp_an;
   logic       exp_dp;

   logic [6:0] hex_tab [16];
   logic [3:0] an_tab  [4];

   typedef struct {
      logic [6:0] r1;
      logic [6:0] r2;
      logic [7:0] sw;
      logic [6:0] e_lo;
      logic [6:0] e_hi;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   seg_scan_driver #(
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .reg1_seg (reg1_seg),
      .reg2_seg (reg2_seg),
      .sw_in    (sw_in),
`ifdef SEG_SCAN_DIM_EN
      .bright   (bright),
`endif
      .seg_out  (seg_out),
      .an_out   (an_out),
      .dp_out   (dp_out)
   );

   // Watchdog in case a loop never terminates
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
      end
   endtask

   // Model update for one rising edge, using the inputs present at it
   task automatic model_edge();
      int  pos;
      int  d;
      int  lit_len;
      bit  lit;
      if (rst == 1'b0) begin
         t       = -1;
         exp_seg = 7'h7F;
         exp_an  = 4'hF;
         exp_dp  = 1'b1;
      end else begin
         t++;
         pos = t % RD;
         d   = (t / RD) % 4;
         if (pos == 0) begin
            m_r1 = reg1_seg;
            m_r2 = reg2_seg;
            m_sw = sw_in;
`ifdef SEG_SCAN_DIM_EN
            m_br = bright;
`endif
         end
`ifdef SEG_SCAN_DIM_EN
         lit_len = ((int'(m_br) + 1) * (RD - BC)) / 4;
`else
         lit_len = RD - BC;
`endif
         lit = (pos >= BC) && (pos < BC + lit_len);
         case (d)
            0:       exp_seg = m_r1;
            1:       exp_seg = m_r2;
            2:       exp_seg = hex_tab[m_sw[3:0]];
            default: exp_seg = hex_tab[m_sw[7:4]];
         endcase
         exp_an = lit ? an_tab[d] : 4'hF;
         exp_dp = (lit && d == 2) ? 1'b0 : 1'b1;
      end
   endtask

   // One clock: model the edge, then compare shortly after it
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_output("seg", {1'b0, seg_out}, {1'b0, exp_seg});
      check_output("an", {4'h0, an_out}, {4'h0, exp_an});
      check_output("dp", {7'h0, dp_out}, {7'h0, exp_dp});
      check_output("an_multi", 8'($countones(~an_out) <= 1), 8'd1);
   endtask

   function automatic int cur_pos();
      return t % RD;
   endfunction

   function automatic int cur_dig();
      return (t / RD) % 4;
   endfunction

   // Run until the model sits at (digit d, position p) after an edge
   task automatic advance_to(input int d, input int p);
      int n = 0;
      while (!(t >= 0 && cur_dig() == d && cur_pos() == p) && n < 2 * FRAME) begin
         tick();
         n++;
      end
      if (!(t >= 0 && cur_dig() == d && cur_pos() == p)) begin
         total++;
         bad++;
         $display("[TB] FAIL advance_to timeout d=%0d p=%0d", d, p);
      end
   endtask

   task automatic apply_stimulus(input logic [6:0] r1, input logic [6:0] r2, input logic [7:0] sw);
      reg1_seg = r1;
      reg2_seg = r2;
      sw_in    = sw;
   endtask

   initial begin
      hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      an_tab  = '{4'hE, 4'hD, 4'hB, 4'h7};

      vecs[0] = '{7'h12, 7'h34, 8'h10, 7'b1000000, 7'b1111001};
      vecs[1] = '{7'h56, 7'h78, 8'h32, 7'b0100100, 7'b0110000};
      vecs[2] = '{7'h1A, 7'h2B, 8'h54, 7'b0011001, 7'b0010010};
      vecs[3] = '{7'h3C, 7'h4D, 8'h76, 7'b0000010, 7'b1111000};
      vecs[4] = '{7'h5E, 7'h6F, 8'h98, 7'b0000000, 7'b0010000};
      vecs[5] = '{7'h01, 7'h7E, 8'hBA, 7'b0001000, 7'b0000011};
      vecs[6] = '{7'h2A, 7'h55, 8'hDC, 7'b1000110, 7'b0100001};
      vecs[7] = '{7'h7F, 7'h00, 8'hFE, 7'b0000110, 7'b0001110};

      rst = 1'b0;
      apply_stimulus(7'b1000000, 7'b1111001, 8'hA5);
`ifdef SEG_SCAN_DIM_EN
      bright = 2'd3;
`endif

      // Reset held for three edges
      repeat (3) tick();
      check_output("rst_seg", {1'b0, seg_out}, 8'h7F);
      check_output("rst_an", {4'h0, an_out}, 8'h0F);
      check_output("rst_dp", {7'h0, dp_out}, 8'h01);

      // Release: two blanked edges then six lit edges of digit 0
      rst = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check_output("rel_seg", {1'b0, seg_out}, {1'b0, 7'b1000000});
         check_output("rel_an", {4'h0, an_out}, (i <= 2) ? 8'h0F : 8'h0E);
      end

      // Remainder of the first frame: slots 1..3
      begin
         logic [6:0] seg_exp [3];
         logic [3:0] an_exp  [3];
         int         lit_cnt [3];
         int         dp_low;
         seg_exp = '{7'b1111001, 7'b0010010, 7'b0001000};
         an_exp  = '{4'hD, 4'hB, 4'h7};
         lit_cnt = '{0, 0, 0};
         dp_low  = 0;
         for (int k = 0; k < 3 * RD; k++) begin
            tick();
            check_output("scan_seg", {1'b0, seg_out}, {1'b0, seg_exp[k / RD]});
            if (an_out == an_exp[k / RD]) lit_cnt[k / RD]++;
            if (dp_out == 1'b0) dp_low++;
         end
         for (int j = 0; j < 3; j++) check_output("scan_litcnt", 8'(lit_cnt[j]), 8'd6);
         check_output("scan_dp_low", 8'(dp_low), 8'd6);
      end

      // Snapshot hold: reg2 changes mid-slot, new value shows next frame
      advance_to(1, 4);
      reg2_seg = 7'b0100100;
      while (cur_pos() != RD - 1) begin
         tick();
         check_output("snap_hold", {1'b0, seg_out}, {1'b0, 7'b1111001});
      end
      advance_to(1, 0);
      check_output("snap_new", {1'b0, seg_out}, {1'b0, 7'b0100100});

      // Table vectors, one frame each
      for (int v = 0; v < 8; v++) begin
         advance_to(3, RD - 1);
         apply_stimulus(vecs[v].r1, vecs[v].r2, vecs[v].sw);
         for (int k = 0; k < FRAME; k++) begin
            tick();
            if (k % RD == BC) begin
               case (k / RD)
                  0:       check_output("vec_r1", {1'b0, seg_out}, {1'b0, vecs[v].r1});
                  1:       check_output("vec_r2", {1'b0, seg_out}, {1'b0, vecs[v].r2});
                  2:       check_output("vec_lo", {1'b0, seg_out}, {1'b0, vecs[v].e_lo});
                  default: check_output("vec_hi", {1'b0, seg_out}, {1'b0, vecs[v].e_hi});
               endcase
            end
         end
      end

`ifdef SEG_SCAN_DIM_EN
      // Dimming: level 1 lights cnt 2..4, level 3 lights cnt 2..7
      advance_to(3, RD - 1);
      bright = 2'd1;
      for (int p = 0; p < RD; p++) begin
         tick();
         check_output("dim1_an", {4'h0, an_out}, (p >= 2 && p <= 4) ? 8'h0E : 8'h0F);
      end
      advance_to(3, RD - 1);
      bright = 2'd3;
      for (int p = 0; p < RD; p++) begin
         tick();
         check_output("dim3_an", {4'h0, an_out}, (p >= 2) ? 8'h0E : 8'h0F);
      end
`endif

      // Mid-slot reset at cnt=5 of digit 3
      advance_to(3, 5);
      rst = 1'b0;
      tick();
      check_output("mrst_an", {4'h0, an_out}, 8'h0F);
      check_output("mrst_seg", {1'b0, seg_out}, 8'h7F);
      check_output("mrst_dp", {7'h0, dp_out}, 8'h01);
      rst = 1'b1;
      tick();
      check_output("mrst_restart_seg", {1'b0, seg_out}, {1'b0, reg1_seg});
      check_output("mrst_restart_an", {4'h0, an_out}, 8'h0F);

      // Three full frames: blanking at slot start, digit order repeats
      advance_to(3, RD - 1);
      for (int k = 0; k < 3 * FRAME; k++) begin
         tick();
         if (k % RD < BC) check_output("wrap_blank", {4'h0, an_out}, 8'h0F);
         if (k % RD == BC) check_output("wrap_an", {4'h0, an_out}, {4'h0, an_tab[(k / RD) % 4]});
      end

      // Random inputs every cycle, with occasional resets
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 3) == 0)
            apply_stimulus(7'($urandom), 7'($urandom), 8'($urandom));
`ifdef SEG_SCAN_DIM_EN
         if ($urandom_range(0, 7) == 0) bright = 2'($urandom);
`endif
         rst = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
